// File: rtl/ma_pkg.sv
// rtl/ma_pkg.sv - shared types and constants for the memory-access stage
package ma_pkg;
    localparam int XLEN  = 32;
    localparam int ERR_W = 2;

    typedef enum logic {
        IDLE,
        ACCESS
    } ma_state_e;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } ma_err_e;

    // Instruction fields carried from EX/MA into MA/RW
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu;
        logic            is_ld;
        logic            is_wb;
        logic            is_call;
    } ma_fields_t;
endpackage

// File: rtl/ma_mem_if.sv
// rtl/ma_mem_if.sv - access FSM, request holding and timeout counter
module ma_mem_if
    import ma_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            is_ld,
    input  logic            is_st,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] st_data,
    input  logic            mem_ack,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            accept,
    output logic            pass,
    output logic            misalign,
    output logic            ack_done,
    output logic            timeout_done
);
    ma_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic memop, aligned, idle, last_cycle;

    assign memop      = in_valid & (is_ld | is_st);
    assign aligned    = (addr[1:0] == 2'b00);
    assign idle       = (state_q == IDLE);
    assign last_cycle = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    assign accept       = idle & memop & aligned;
    assign misalign     = idle & memop & ~aligned;
    assign pass         = idle & ~memop;
    assign ack_done     = ~idle & mem_ack;
    assign timeout_done = ~idle & ~mem_ack & last_cycle;
    assign stall        = accept | (~idle & ~mem_ack);

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            state_d = ACCESS;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = is_st & ~is_ld;   // ld+st together behaves as a load
            addr_d  = addr;
            wdata_d = st_data;
        end else if (ack_done || timeout_done) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end else if (!idle) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: rtl/ma_stage.sv
// rtl/ma_stage.sv - memory-access pipeline stage with MA/RW output register
module ma_stage
    import ma_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  Instruction,
    input  logic [XLEN-1:0]  pc_current,
    input  logic [XLEN-1:0]  AluResult,
    input  logic [XLEN-1:0]  Op2,
    input  logic             IsLd,
    input  logic             IsSt,
    input  logic             IsWb,
    input  logic             IsCall,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_Instruction,
    output logic [XLEN-1:0]  out_pc_current,
    output logic [XLEN-1:0]  out_AluResult,
    output logic [XLEN-1:0]  out_LdResult,
    output logic             out_IsLd,
    output logic             out_IsWb,
    output logic             out_IsCall,
    output logic [ERR_W-1:0] out_err
);
    logic accept, pass, misalign, ack_done, timeout_done;

    ma_fields_t       in_f;
    ma_fields_t       lat_q, lat_d;
    ma_fields_t       out_q, out_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  ld_q, ld_d;
    logic [ERR_W-1:0] err_q, err_d;

    ma_mem_if #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_mem_if (
        .clk          (Clk),
        .reset        (Reset),
        .in_valid     (in_valid),
        .is_ld        (IsLd),
        .is_st        (IsSt),
        .addr         (AluResult),
        .st_data      (Op2),
        .mem_ack      (mem_ack),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .accept       (accept),
        .pass         (pass),
        .misalign     (misalign),
        .ack_done     (ack_done),
        .timeout_done (timeout_done)
    );

    assign in_f = '{instr: Instruction, pc: pc_current, alu: AluResult,
                    is_ld: IsLd, is_wb: IsWb, is_call: IsCall};

    always_comb begin
        lat_d   = lat_q;
        out_d   = out_q;
        valid_d = valid_q;
        ld_d    = ld_q;
        err_d   = err_q;
        if (pass) begin
            out_d         = in_f;
            out_d.is_ld   = IsLd & in_valid;
            out_d.is_wb   = IsWb & in_valid;
            out_d.is_call = IsCall & in_valid;
            valid_d       = in_valid;
            ld_d          = '0;
            err_d         = ERR_NONE;
        end else if (misalign) begin
            out_d       = in_f;
            out_d.is_wb = 1'b0;
            valid_d     = 1'b1;
            ld_d        = '0;
            err_d       = ERR_MISALIGN;
        end else if (accept) begin
            // RW sees a bubble while the access is outstanding
            lat_d         = in_f;
            out_d.is_ld   = 1'b0;
            out_d.is_wb   = 1'b0;
            out_d.is_call = 1'b0;
            valid_d       = 1'b0;
        end else if (ack_done) begin
            out_d   = lat_q;
            valid_d = 1'b1;
            ld_d    = lat_q.is_ld ? mem_rdata : '0;
            err_d   = ERR_NONE;
        end else if (timeout_done) begin
            out_d       = lat_q;
            out_d.is_wb = 1'b0;
            valid_d     = 1'b1;
            ld_d        = '0;
            err_d       = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lat_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ld_q    <= '0;
            err_q   <= ERR_NONE;
        end else begin
            lat_q   <= lat_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_Instruction = out_q.instr;
    assign out_pc_current  = out_q.pc;
    assign out_AluResult   = out_q.alu;
    assign out_IsLd        = out_q.is_ld;
    assign out_IsWb        = out_q.is_wb;
    assign out_IsCall      = out_q.is_call;
    assign out_LdResult    = ld_q;
    assign out_err         = err_q;
endmodule

// File: tb/tb_ma_stage.sv
// tb/tb_ma_stage.sv - randomized self-checking bench for ma_stage
module tb_ma_stage;
    localparam int MT = 4;

    logic        Clk = 1'b0;
    logic        Reset, in_valid, IsLd, IsSt, IsWb, IsCall, mem_ack;
    logic [31:0] Instruction, pc_current, AluResult, Op2, mem_rdata;
    logic        stall, mem_req, mem_we, out_valid, out_IsLd, out_IsWb, out_IsCall;
    logic [31:0] mem_addr, mem_wdata, out_Instruction, out_pc_current, out_AluResult, out_LdResult;
    logic [1:0]  out_err;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    ma_stage #(.MEM_TIMEOUT(MT), .CNT_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .Instruction(Instruction),
        .pc_current(pc_current), .AluResult(AluResult), .Op2(Op2), .IsLd(IsLd),
        .IsSt(IsSt), .IsWb(IsWb), .IsCall(IsCall), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_Instruction(out_Instruction),
        .out_pc_current(out_pc_current), .out_AluResult(out_AluResult),
        .out_LdResult(out_LdResult), .out_IsLd(out_IsLd), .out_IsWb(out_IsWb),
        .out_IsCall(out_IsCall), .out_err(out_err)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One instruction through the stage; w = wait cycles before ack (w >= MT means none)
    task automatic run_op(input bit ld, input bit st, input bit wb, input bit call,
                          input logic [31:0] addr, input logic [31:0] op2,
                          input logic [31:0] rd, input int w, input string tag);
        logic [31:0] ins, pc;
        bit memop, aligned, exp_we, done;
        ins = $urandom; pc = $urandom;
        memop = ld | st; aligned = (addr[1:0] == 2'b00); exp_we = st & ~ld; done = 0;
        in_valid = 1; Instruction = ins; pc_current = pc; AluResult = addr; Op2 = op2;
        IsLd = ld; IsSt = st; IsWb = wb; IsCall = call; mem_ack = 0; mem_rdata = $urandom;
        #1;
        if (!memop || !aligned) begin
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL %s stall got=%b want=0", tag, stall); end
            tick();
            in_valid = 0;
            total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL %s mem_req got=%b want=0", tag, mem_req); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s out_valid got=%b want=1", tag, out_valid); end
            total++; if (out_err !== (memop ? 2'd1 : 2'd0)) begin bad++; $display("FAIL %s out_err got=%0d want=%0d", tag, out_err, memop); end
            total++; if (out_IsWb !== (memop ? 1'b0 : wb)) begin bad++; $display("FAIL %s out_IsWb got=%b", tag, out_IsWb); end
            total++; if (out_IsLd !== ld || out_IsCall !== call) begin bad++; $display("FAIL %s ld/call got=%b%b want=%b%b", tag, out_IsLd, out_IsCall, ld, call); end
            total++; if (out_AluResult !== addr || out_Instruction !== ins || out_pc_current !== pc) begin bad++; $display("FAIL %s fields got alu=%h want=%h", tag, out_AluResult, addr); end
            total++; if (out_LdResult !== 32'h0) begin bad++; $display("FAIL %s out_LdResult got=%h want=0", tag, out_LdResult); end
        end else begin
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL %s accept stall got=%b want=1", tag, stall); end
            tick();
            for (int i = 0; i < MT && !done; i++) begin
                total++; if (mem_req !== 1'b1 || mem_we !== exp_we) begin bad++; $display("FAIL %s req/we cyc%0d got=%b%b want=1%b", tag, i, mem_req, mem_we, exp_we); end
                total++; if (mem_addr !== addr || mem_wdata !== op2) begin bad++; $display("FAIL %s addr/wdata cyc%0d got=%h/%h want=%h/%h", tag, i, mem_addr, mem_wdata, addr, op2); end
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s bubble cyc%0d out_valid got=%b want=0", tag, i, out_valid); end
                if (i == w) begin
                    mem_ack = 1; mem_rdata = rd; #1;
                    total++; if (stall !== 1'b0) begin bad++; $display("FAIL %s ack-cycle stall got=%b want=0", tag, stall); end
                    tick();
                    mem_ack = 0; mem_rdata = $urandom; in_valid = 0; done = 1;
                    total++; if (out_valid !== 1'b1 || out_err !== 2'd0) begin bad++; $display("FAIL %s done valid/err got=%b/%0d want=1/0", tag, out_valid, out_err); end
                    total++; if (out_LdResult !== (ld ? rd : 32'h0)) begin bad++; $display("FAIL %s out_LdResult got=%h want=%h", tag, out_LdResult, ld ? rd : 32'h0); end
                    total++; if (out_IsWb !== wb || out_IsLd !== ld || out_IsCall !== call) begin bad++; $display("FAIL %s ctl got=%b%b%b want=%b%b%b", tag, out_IsWb, out_IsLd, out_IsCall, wb, ld, call); end
                    total++; if (out_AluResult !== addr || out_Instruction !== ins || out_pc_current !== pc) begin bad++; $display("FAIL %s fields got alu=%h want=%h", tag, out_AluResult, addr); end
                end else begin
                    total++; if (stall !== 1'b1) begin bad++; $display("FAIL %s wait stall cyc%0d got=%b want=1", tag, i, stall); end
                    tick();
                end
            end
            if (!done) begin
                in_valid = 0;
                total++; if (out_valid !== 1'b1 || out_err !== 2'd2) begin bad++; $display("FAIL %s timeout valid/err got=%b/%0d want=1/2", tag, out_valid, out_err); end
                total++; if (out_IsWb !== 1'b0 || out_LdResult !== 32'h0) begin bad++; $display("FAIL %s timeout wb/ld got=%b/%h want=0/0", tag, out_IsWb, out_LdResult); end
                total++; if (out_AluResult !== addr) begin bad++; $display("FAIL %s timeout alu got=%h want=%h", tag, out_AluResult, addr); end
            end
            total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL %s req after done got=%b want=0", tag, mem_req); end
        end
    endtask

    task automatic test_reset();
        Reset = 1; in_valid = 0; Instruction = 0; pc_current = 0; AluResult = 0; Op2 = 0;
        IsLd = 0; IsSt = 0; IsWb = 0; IsCall = 0; mem_ack = 0; mem_rdata = 0;
        tick(); tick();
        Reset = 0; #1;
        total++; if (mem_req !== 0 || stall !== 0 || out_valid !== 0) begin bad++; $display("FAIL reset req/stall/valid got=%b%b%b want=000", mem_req, stall, out_valid); end
        total++; if (out_err !== 0 || out_LdResult !== 0 || out_AluResult !== 0 || mem_addr !== 0) begin bad++; $display("FAIL reset data err=%0d ld=%h alu=%h", out_err, out_LdResult, out_AluResult); end
        total++; if (out_IsWb !== 0 || out_IsLd !== 0 || out_IsCall !== 0 || mem_we !== 0) begin bad++; $display("FAIL reset ctl got=%b%b%b%b", out_IsWb, out_IsLd, out_IsCall, mem_we); end
    endtask

    task automatic test_directed();
        run_op(0, 0, 1, 0, 32'h0000_0010, 32'h0, 32'h0, 0, "add");
        run_op(1, 0, 1, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2, "load3");
        run_op(0, 1, 0, 0, 32'h0000_0200, 32'h1234_5678, 32'hFFFF_FFFF, 0, "store_imm");
        run_op(1, 0, 1, 0, 32'h0000_0102, 32'h0, 32'h0, 0, "misalign");
        run_op(1, 0, 1, 1, 32'h0000_0300, 32'h0, 32'hCAFE_0001, MT - 1, "ack_at_limit");
        run_op(1, 1, 1, 0, 32'h0000_0400, 32'h5555_AAAA, 32'h0BAD_F00D, 1, "ld_st_both");
    endtask

    task automatic test_bubble();
        in_valid = 0; IsWb = 1; IsLd = 1; IsSt = 1; IsCall = 1; AluResult = 32'h40; #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL bubble stall got=%b want=0", stall); end
        tick();
        total++; if (out_valid !== 0 || out_IsWb !== 0 || out_IsLd !== 0 || out_IsCall !== 0 || mem_req !== 0) begin bad++; $display("FAIL bubble got v=%b wb=%b ld=%b call=%b req=%b", out_valid, out_IsWb, out_IsLd, out_IsCall, mem_req); end
        IsSt = 0;
    endtask

    task automatic test_timeout();
        run_op(1, 0, 1, 0, 32'h0000_0500, 32'h0, 32'h0, 99, "timeout");
        mem_ack = 1; mem_rdata = 32'h7777_7777; in_valid = 0;
        tick();
        mem_ack = 0;
        total++; if (mem_req !== 0 || out_valid !== 0 || out_LdResult !== 0) begin bad++; $display("FAIL late_ack got req=%b v=%b ld=%h want=0/0/0", mem_req, out_valid, out_LdResult); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1; IsLd = 1; IsSt = 0; IsWb = 1; IsCall = 0; AluResult = 32'h600; mem_ack = 0;
        tick(); tick();
        Reset = 1; in_valid = 0;
        tick();
        Reset = 0; #1;
        total++; if (mem_req !== 0 || stall !== 0 || out_valid !== 0) begin bad++; $display("FAIL reset_mid got req=%b stall=%b v=%b want=000", mem_req, stall, out_valid); end
        mem_ack = 1; mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 0;
        total++; if (mem_req !== 0 || out_valid !== 0 || out_LdResult !== 0) begin bad++; $display("FAIL reset_mid ack ignored got req=%b v=%b ld=%h", mem_req, out_valid, out_LdResult); end
        run_op(1, 0, 1, 0, 32'h0000_0604, 32'h0, 32'hA5A5_5A5A, 1, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_op(kind == 1 || kind == 3, kind == 2 || kind == 3, 1'($urandom), 1'($urandom),
                   a, $urandom, $urandom, $urandom_range(0, MT + 1), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_bubble();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
